// File: rtl/soc_system_edge_pio.sv
// soc_system_edge_pio: debounced edge-capture PIO with Avalon-MM registers and level irq
module soc_system_edge_pio #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
   logic [DEBOUNCE_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0]      sync, filt, filt_d, edgecap, irqmask, rise_en, fall_en, events, wd;
   logic [DEBOUNCE_W-1:0] debounce;
   logic [31:0]           rd_next;
   logic                  wr, unused_ok;
   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_ok = ^writedata;
   assign sync      = sync_q[SYNC_STAGES-1];
   assign events    = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
   assign irq       = |(edgecap & irqmask);
   // metastability chain on the raw pins
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end
   // per-channel debounce: filt follows sync once it differs for debounce+1 cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         filt   <= '0;
         filt_d <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         filt_d <= filt;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == debounce) begin
               filt[i] <= sync[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end
   // control registers; a new edge event beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         edgecap  <= '0;
         irqmask  <= '0;
         rise_en  <= '1;
         fall_en  <= '0;
         debounce <= '0;
      end else begin
         edgecap <= (edgecap & ~((wr && address == 3'd3) ? wd : '0)) | events;
         if (wr && address == 3'd2) irqmask  <= wd;
         if (wr && address == 3'd4) rise_en  <= wd;
         if (wr && address == 3'd5) fall_en  <= wd;
         if (wr && address == 3'd6) debounce <= writedata[DEBOUNCE_W-1:0];
      end
   end
   // read mux, zero-extended; unmapped addresses return 0
   always_comb begin
      rd_next = (address == 3'd0) ? 32'(filt)     :
                (address == 3'd2) ? 32'(irqmask)  :
                (address == 3'd3) ? 32'(edgecap)  :
                (address == 3'd4) ? 32'(rise_en)  :
                (address == 3'd5) ? 32'(fall_en)  :
                (address == 3'd6) ? 32'(debounce) : 32'd0;
   end
   // registered read data, updated every cycle regardless of chipselect
   always_ff @(posedge clk) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_next;
   end
endmodule

// File: tb/tb_soc_system_edge_pio.sv
// tb_soc_system_edge_pio: directed checks of the edge-capture PIO register behaviour
module tb_soc_system_edge_pio;
   logic        clk = 0;
   logic        reset = 1;
   logic [2:0]  address = '0;
   logic        chipselect = 0;
   logic        write_n = 1;
   logic [31:0] writedata = '0;
   logic [7:0]  in_port = '0;
   logic [31:0] readdata;
   logic        irq;
   int          tests = 0;
   int          errors = 0;
   logic [31:0] v;

   soc_system_edge_pio dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1;
      write_n = 0;
      address = a;
      writedata = d;
      tick();
      chipselect = 0;
      write_n = 1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   initial begin
      tick(2);
      bus_write(3'd2, 32'hFF);
      reset = 1;
      tick();
      check("rst_readdata", readdata, 0);
      check("rst_irq", {31'd0, irq}, 0);
      reset = 0;
      bus_read(3'd4, v); check("rst_rise_en", v, 32'hFF);
      bus_read(3'd2, v); check("rst_irqmask_write_ignored", v, 0);
      bus_read(3'd6, v); check("rst_debounce", v, 0);

      address = 3'd0;
      in_port = 8'h01;
      tick(3);
      check("data_before_latency", readdata, 0);
      tick();
      check("data_at_latency", readdata, 32'h01);
      bus_read(3'd3, v); check("edgecap_rise0", v, 32'h01);
      check("irq_masked", {31'd0, irq}, 0);
      bus_write(3'd2, 32'h01);
      check("irq_unmasked", {31'd0, irq}, 1);
      bus_write(3'd3, 32'h01);
      bus_read(3'd3, v); check("edgecap_cleared", v, 0);
      check("irq_after_clear", {31'd0, irq}, 0);

      bus_write(3'd4, 32'h00);
      bus_write(3'd5, 32'h80);
      in_port = 8'h81;
      tick(6);
      bus_read(3'd3, v); check("rise_disabled", v, 0);
      bus_read(3'd0, v); check("data_updates_disabled", v, 32'h81);
      in_port = 8'h01;
      tick(6);
      bus_read(3'd3, v); check("fall_captured", v, 32'h80);
      in_port = 8'h81;
      tick(6);
      bus_read(3'd3, v); check("rise_still_ignored", v, 32'h80);
      in_port = 8'h01;
      tick(6);
      bus_write(3'd3, 32'hFF);
      bus_write(3'd4, 32'hFF);
      bus_write(3'd5, 32'h00);

      bus_write(3'd6, 32'd10);
      bus_read(3'd6, v); check("debounce_rb", v, 32'd10);
      address = 3'd0;
      in_port = 8'h05;
      tick(5);
      in_port = 8'h01;
      tick(20);
      check("glitch_data", readdata, 32'h01);
      bus_read(3'd3, v); check("glitch_edgecap", v, 0);
      address = 3'd0;
      tick(2);
      in_port = 8'h05;
      tick(13);
      check("deb_data_early", readdata, 32'h01);
      tick();
      check("deb_data_on_time", readdata, 32'h05);
      tick(6);
      in_port = 8'h01;
      bus_read(3'd3, v); check("deb_edgecap", v, 32'h04);
      tick(15);
      bus_write(3'd3, 32'hFF);

      bus_write(3'd6, 32'd0);
      bus_read(3'd3, v); check("edgecap_pre_race", v, 0);
      in_port = 8'h05;
      tick(3);
      bus_write(3'd3, 32'h04);
      bus_read(3'd3, v); check("set_beats_clear", v, 32'h04);
      bus_write(3'd3, 32'h04);
      bus_read(3'd3, v); check("clear_after_race", v, 0);
      bus_write(3'd2, 32'hFFFFFF00);
      bus_read(3'd2, v); check("irqmask_upper_ignored", v, 0);

      bus_write(3'd2, 32'h0F);
      bus_write(3'd5, 32'h0F);
      bus_write(3'd6, 32'd3);
      in_port = 8'hFF;
      tick(12);
      address = 3'd3;
      reset = 1;
      tick(2);
      check("rst2_readdata", readdata, 0);
      check("rst2_irq", {31'd0, irq}, 0);
      reset = 0;
      tick();
      check("rst2_edgecap_cleared", readdata, 0);
      begin
         int n = 0;
         while (readdata !== 32'hFF && n < 6) begin
            tick();
            n++;
         end
         check("rst2_edgecap_all", readdata, 32'hFF);
         check("rst2_edgecap_latency_ok", {31'd0, n <= 4}, 1);
      end
      bus_read(3'd2, v); check("rst2_irqmask", v, 0);
      bus_read(3'd4, v); check("rst2_rise_en", v, 32'hFF);
      bus_read(3'd5, v); check("rst2_fall_en", v, 0);
      bus_read(3'd6, v); check("rst2_debounce", v, 0);
      bus_read(3'd0, v); check("rst2_data", v, 32'hFF);
      bus_write(3'd2, 32'h10);
      check("rst2_irq_mask", {31'd0, irq}, 1);

      bus_read(3'd1, v); check("addr1_zero", v, 0);
      bus_read(3'd7, v); check("addr7_zero", v, 0);
      bus_write(3'd0, 32'h00);
      bus_read(3'd0, v); check("data_write_ignored", v, 32'hFF);
      bus_write(3'd6, 32'hFFFFFFFF);
      bus_read(3'd6, v); check("debounce_width", v, 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
